// File: rtl/shader_instr_dispatch.sv
// Multi-channel shader instruction dispatcher: per-channel FIFOs merged by a
// round-robin arbiter onto one registered valid/ready output port.
module shader_instr_dispatch #(
    parameter int N_CH     = 4,
    parameter int OPCODE_W = 4,
    parameter int DEPTH    = 4,
    localparam int CH_W    = $clog2(N_CH),
    localparam int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic [N_CH*OPCODE_W-1:0] in_opcode,
    input  logic [N_CH-1:0]          in_is_vector,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPCODE_W-1:0]      out_opcode,
    output logic                     out_is_vector,
    output logic [CH_W-1:0]          out_ch,
    output logic [N_CH*LVL_W-1:0]    fifo_level,
    output logic                     err_illegal_op
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = OPCODE_W + 1;

    logic [ENT_W-1:0] mem      [N_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr   [N_CH];
    logic [PTR_W-1:0] rd_ptr   [N_CH];
    logic [LVL_W-1:0] count    [N_CH];
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  pop;
    logic [N_CH-1:0]  illegal;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  grant;
    logic             grant_valid;
    logic             load;
    int               idx;

    // Readiness comes only from the registered count, so a full FIFO never
    // accepts even when it is being popped in the same cycle.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign in_ready[c]   = rst_n && !flush && (count[c] != LVL_W'(DEPTH));
        assign push[c]       = in_valid[c] && in_ready[c];
        assign pop[c]        = load && (grant == CH_W'(c));
        assign illegal[c]    = push[c] && (32'(in_opcode[c*OPCODE_W +: OPCODE_W]) >= 32'd4);
        assign fifo_level[c*LVL_W +: LVL_W] = count[c];
    end

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr_ptr) + i) % N_CH;
            if (!grant_valid && count[idx] != '0) begin
                grant_valid = 1'b1;
                grant       = CH_W'(idx);
            end
        end
    end

    assign load = (!out_valid || out_ready) && grant_valid && !flush;

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (push[c])
                mem[c][wr_ptr[c]] <= {in_is_vector[c], in_opcode[c*OPCODE_W +: OPCODE_W]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else if (flush) begin
            for (int c = 0; c < N_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (push[c])
                    wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                if (pop[c])
                    rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                if (push[c] && !pop[c])
                    count[c] <= count[c] + LVL_W'(1);
                else if (!push[c] && pop[c])
                    count[c] <= count[c] - LVL_W'(1);
            end
        end
    end

    // rr_ptr holds the channel where the next search begins (last grant + 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_opcode    <= '0;
            out_is_vector <= 1'b0;
            out_ch        <= '0;
            rr_ptr        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid                   <= 1'b1;
            {out_is_vector, out_opcode} <= mem[grant][rd_ptr[grant]];
            out_ch                      <= grant;
            rr_ptr                      <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_illegal_op <= 1'b0;
        else if (flush)
            err_illegal_op <= 1'b0;
        else if (|illegal)
            err_illegal_op <= 1'b1;
    end

endmodule

// File: tb/tb_shader_instr_dispatch.sv
// Directed scoreboard bench for shader_instr_dispatch: stimulus pushes expected
// {ch, vec, opcode} entries, a monitor pops and compares on each output transfer.
module tb_shader_instr_dispatch;
    localparam int N_CH     = 4;
    localparam int OPCODE_W = 4;
    localparam int DEPTH    = 4;
    localparam int CH_W     = 2;
    localparam int LVL_W    = 3;

    logic                     clk;
    logic                     rst_n;
    logic                     flush;
    logic [N_CH-1:0]          in_valid;
    logic [N_CH-1:0]          in_ready;
    logic [N_CH*OPCODE_W-1:0] in_opcode;
    logic [N_CH-1:0]          in_is_vector;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPCODE_W-1:0]      out_opcode;
    logic                     out_is_vector;
    logic [CH_W-1:0]          out_ch;
    logic [N_CH*LVL_W-1:0]    fifo_level;
    logic                     err_illegal_op;

    logic [CH_W+OPCODE_W:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    shader_instr_dispatch #(.N_CH(N_CH), .OPCODE_W(OPCODE_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_is_vector(in_is_vector), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_is_vector(out_is_vector), .out_ch(out_ch),
        .fifo_level(fifo_level), .err_illegal_op(err_illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_value("sb_unexpected_out", {25'd0, out_ch, out_is_vector, out_opcode}, 32'hFFFF_FFFF);
            end else begin
                check_value("sb_out", {25'd0, out_ch, out_is_vector, out_opcode}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_one(input int ch, input logic [OPCODE_W-1:0] op, input logic vec, input bit expect_out);
        int t;
        @(negedge clk);
        for (t = 0; t < 20 && !in_ready[ch]; t++) @(negedge clk);
        if (!in_ready[ch]) check_value("push_ready_timeout", 32'(in_ready[ch]), 32'd1);
        in_valid[ch]                      = 1'b1;
        in_opcode[ch*OPCODE_W +: OPCODE_W] = op;
        in_is_vector[ch]                  = vec;
        if (expect_out) exp_q.push_back({CH_W'(ch), vec, op});
        @(posedge clk);
        #1 in_valid[ch] = 1'b0;
    endtask

    task automatic do_flush();
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge clk);
        check_value("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [OPCODE_W-1:0] t3_ops [5];
        t3_ops = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2};
        rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_opcode = '0;
        in_is_vector = '0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_in_ready", 32'(in_ready), 32'd0);
        check_value("rst_level", 32'(fifo_level), 32'd0);
        check_value("rst_err", 32'(err_illegal_op), 32'd0);
        check_value("rst_out_ch", 32'(out_ch), 32'd0);
        rst_n = 1'b1;
        #1 check_value("post_rst_in_ready", 32'(in_ready), 32'hF);
        out_ready = 1'b1;

        // Test 1: single push latency
        push_one(2, 4'd3, 1'b1, 1'b1);
        @(negedge clk);
        check_value("t1_valid_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_value("t1_valid_latency", 32'(out_valid), 32'd1);
        wait_drain();

        // Test 2: all channels, round-robin from channel 0
        do_flush();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < N_CH; c++)
                exp_q.push_back({CH_W'(c), k[0], (k == 0) ? OPCODE_W'(c) : OPCODE_W'(3 - c)});
        @(negedge clk);
        in_valid = 4'hF; in_opcode = {4'd3, 4'd2, 4'd1, 4'd0}; in_is_vector = 4'h0;
        @(posedge clk);
        #1 in_opcode = {4'd0, 4'd1, 4'd2, 4'd3}; in_is_vector = 4'hF;
        @(posedge clk);
        #1 in_valid = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_value("t2_back_to_back", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        check_value("t2_idle_after", 32'(out_valid), 32'd0);
        wait_drain();

        // Test 3: backpressure fills channel 0
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_one(0, t3_ops[k], k[0], 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("t3_level", 32'(fifo_level[0 +: LVL_W]), 32'd4);
            check_value("t3_in_ready0", 32'(in_ready[0]), 32'd0);
            check_value("t3_hold", {24'd0, out_valid, out_ch, out_is_vector, out_opcode}, {24'd0, 1'b1, 2'd0, 1'b0, 4'd1});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();

        // Test 4: reserved opcode sets sticky error
        check_value("t4_err_before", 32'(err_illegal_op), 32'd0);
        push_one(1, 4'd7, 1'b0, 1'b1);
        @(negedge clk);
        check_value("t4_err_set", 32'(err_illegal_op), 32'd1);
        wait_drain();
        repeat (3) @(negedge clk);
        check_value("t4_err_sticky", 32'(err_illegal_op), 32'd1);
        do_flush();
        @(negedge clk);
        check_value("t4_err_flushed", 32'(err_illegal_op), 32'd0);

        // Test 5: flush with buffered data
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 3; k++) push_one(0, 4'd2, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) push_one(1, 4'd1, 1'b1, 1'b0);
        @(negedge clk);
        check_value("t5_valid_pre", 32'(out_valid), 32'd1);
        check_value("t5_level_pre", 32'(fifo_level), {20'd0, 12'h012});
        do_flush();
        @(negedge clk);
        check_value("t5_valid_post", 32'(out_valid), 32'd0);
        check_value("t5_level_post", 32'(fifo_level), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_value("t5_stays_empty", 32'(out_valid), 32'd0);

        // Test 6: asynchronous reset mid-traffic
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        in_valid = 4'hF; in_opcode = {4'd9, 4'd1, 4'd2, 4'd3}; in_is_vector = 4'h5;
        repeat (3) @(posedge clk);
        #1 in_valid = 4'h0;
        @(negedge clk);
        check_value("t6_valid_pre", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("t6_rst_valid", 32'(out_valid), 32'd0);
        check_value("t6_rst_in_ready", 32'(in_ready), 32'd0);
        check_value("t6_rst_level", 32'(fifo_level), 32'd0);
        check_value("t6_rst_err", 32'(err_illegal_op), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_value("t6_in_ready_after", 32'(in_ready), 32'hF);
        out_ready = 1'b1;
        push_one(3, 4'd2, 1'b1, 1'b1);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
